// File: rtl/taylor_io_host.sv
// rtl/taylor_io_host.sv - host-side adapter for the processor's one-hot integer I/O ports
module taylor_io_host #(
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int NBIN   = 19,
  parameter int NBOUT  = 28,
  parameter int FDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_err,
  input  logic [NUIOIN*NBIN-1:0]  src_data,
  input  logic [NUIOIN-1:0]       src_valid,
  output logic [NUIOIN-1:0]       src_ready,
  output logic [NBIN-1:0]         io_in,
  input  logic [NUIOIN-1:0]       req_in,
  input  logic [NBOUT-1:0]        io_out,
  input  logic [NUIOOU-1:0]       out_en,
  output logic [NUIOOU*NBOUT-1:0] snk_data,
  output logic [NUIOOU-1:0]       snk_valid,
  input  logic [NUIOOU-1:0]       snk_ready,
  output logic [NUIOIN-1:0]       underrun,
  output logic [NUIOOU-1:0]       overrun
);

  localparam int AW = $clog2(FDEPTH);

  logic [NBIN-1:0]          mem_q    [NUIOIN][FDEPTH];
  logic [AW:0]              wr_ptr_q [NUIOIN];
  logic [AW:0]              wr_ptr_d [NUIOIN];
  logic [AW:0]              rd_ptr_q [NUIOIN];
  logic [AW:0]              rd_ptr_d [NUIOIN];
  logic [NUIOIN-1:0]        empty, full, push, pop, req_oh;
  logic [NUIOIN-1:0]        underrun_q, underrun_d;
  logic [NUIOOU-1:0]        cap_oh;
  logic [NUIOOU-1:0]        snk_valid_q, snk_valid_d;
  logic [NUIOOU-1:0]        overrun_q, overrun_d;
  logic [NUIOOU*NBOUT-1:0]  snk_data_q, snk_data_d;

  // Multi-hot strobes collapse to their lowest set bit, so extra bits do nothing.
  assign req_oh = req_in & (~req_in + NUIOIN'(1));
  assign cap_oh = out_en & (~out_en + NUIOOU'(1));

  // FIFO status from the extra-MSB pointer scheme.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
      full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                 (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
    end
  end

  assign src_ready = ~full;
  assign push      = src_valid & ~full;
  assign pop       = req_oh & ~empty;

  // Present the selected FIFO head; zero when nothing is requested or it is empty.
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (pop[k]) io_in = mem_q[k][rd_ptr_q[k][AW-1:0]];
    end
  end

  // Next pointers and sticky underrun; a same-cycle set beats clr_err.
  always_comb begin
    for (int k = 0; k < NUIOIN; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k] + {{AW{1'b0}}, push[k]};
      rd_ptr_d[k] = rd_ptr_q[k] + {{AW{1'b0}}, pop[k]};
    end
    underrun_d = (underrun_q & ~{NUIOIN{clr_err}}) | (req_oh & empty);
  end

  // Output holding registers: capture wins over accept, overwrite of unaccepted data flags overrun.
  always_comb begin
    snk_data_d  = snk_data_q;
    snk_valid_d = cap_oh | (snk_valid_q & ~snk_ready);
    overrun_d   = (overrun_q & ~{NUIOOU{clr_err}}) | (cap_oh & snk_valid_q & ~snk_ready);
    for (int k = 0; k < NUIOOU; k++) begin
      if (cap_oh[k]) snk_data_d[k*NBOUT +: NBOUT] = io_out;
    end
  end

  // FIFO sample storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUIOIN; k++) begin
        for (int e = 0; e < FDEPTH; e++) mem_q[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < NUIOIN; k++) begin
        if (push[k]) mem_q[k][wr_ptr_q[k][AW-1:0]] <= src_data[k*NBIN +: NBIN];
      end
    end
  end

  // Control state register; reset empties every FIFO and clears every holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUIOIN; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      underrun_q  <= '0;
      snk_data_q  <= '0;
      snk_valid_q <= '0;
      overrun_q   <= '0;
    end else begin
      for (int k = 0; k < NUIOIN; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
      underrun_q  <= underrun_d;
      snk_data_q  <= snk_data_d;
      snk_valid_q <= snk_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign snk_data  = snk_data_q;
  assign snk_valid = snk_valid_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/taylor_io_host.md
# taylor_io_host

Host-side adapter for the other end of the floating-point processor's one-hot I/O port handshake. It feeds the processor's integer input bus from per-port sample FIFOs whenever the processor strobes `req_in`, and captures the processor's integer output bus into per-port holding registers on `out_en`. It also presents both sides to the surrounding system as valid/ready streams. It sits between the acquisition/sink logic and the processor wrapper (integer side, after the float conversions).

## Interface
- `NUIOIN`, 4: number of processor input ports.
- `NUIOOU`, 4: number of processor output ports.
- `NBIN`, 19: input sample width, signed.
- `NBOUT`, 28: output sample width, signed.
- `FDEPTH`, 4: entries per input FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr_err`  in  1  synchronous clear of sticky error flags.
- `src_data`  in  NUIOIN*NBIN  upstream samples; port k occupies bits [k*NBIN +: NBIN].
- `src_valid`  in  NUIOIN  upstream valid per port.
- `src_ready`  out  NUIOIN  FIFO k not full.
- `io_in`  out  NBIN  sample presented to the processor.
- `req_in`  in  NUIOIN  one-hot read strobe from the processor.
- `io_out`  in  NBOUT  processor output sample.
- `out_en`  in  NUIOOU  one-hot write strobe from the processor.
- `snk_data`  out  NUIOOU*NBOUT  held output per port; same packing as `src_data`.
- `snk_valid`  out  NUIOOU  holding register k occupied.
- `snk_ready`  in  NUIOOU  downstream accepts port k.
- `underrun`  out  NUIOIN  sticky: processor read an empty FIFO.
- `overrun`  out  NUIOOU  sticky: unconsumed output overwritten.

## Operation
- **Input side:**
  - One FIFO per input port, `FDEPTH` entries, with read/write pointers of log2(`FDEPTH`)+1 bits.
  - `full` when the pointers differ only in the MSB; `empty` when they are equal.
  - Push on `src_valid[k] & src_ready[k]`. `src_ready[k] = ~full[k]` (combinational).
- **Port select:** the selected port is the lowest set bit of `req_in`. Any other set bits are ignored; multi-hot strobes are illegal but must be harmless.
- **io_in:** combinational head of the selected FIFO. It is 0 when `req_in` is all zero or the selected FIFO is empty.
- **Pop:** on the edge where `req_in` selects k and FIFO k is non-empty.
- **Empty read:** no pop, `io_in` = 0, `underrun[k]` set.
- **Simultaneous push and pop, same FIFO:** both take effect and occupancy is unchanged. There is no empty bypass: a pop attempted while empty is an underrun even if a push occurs in the same cycle.
- **Full FIFO:** a push is refused because `src_ready` is low, even if a pop occurs in the same cycle.
- **Output side:** one register plus valid flag per output port. The selected port is the lowest set bit of `out_en`.
  - `out_en[k]` with `snk_valid[k]` = 0, or with `snk_valid[k] & snk_ready[k]` in the same cycle: load `io_out`, `snk_valid[k]` = 1, no error.
  - `out_en[k]` with `snk_valid[k] & ~snk_ready[k]`: overwrite data and set `overrun[k]`.
  - `snk_valid[k] & snk_ready[k]` with no `out_en[k]`: clear `snk_valid[k]`; data is retained.
- **Errors:** `underrun`/`overrun` are cleared by `clr_err` or `rst`. A set event in the same cycle as `clr_err` wins, so the flag ends at 1.

## Timing
- **Reset values:**
  - FIFOs empty and `src_ready` = all 1.
  - `io_in` = 0, `snk_data` = 0, `snk_valid` = 0.
  - `underrun` = 0, `overrun` = 0.
- **Reset mid-operation:** all stored samples are discarded immediately (asynchronous). No partial-transfer recovery.
- **Input latency:**
  - A sample pushed at edge t is visible on `io_in` when requested at cycle t+1 or later.
  - `io_in` is valid in the same cycle `req_in` is high; the processor samples it at that cycle's edge.
- **Back-to-back reads:** consecutive `req_in` cycles on the same port return consecutive FIFO entries.
- **Output latency:** `io_out` is captured at the edge where `out_en` is high, so `snk_valid` rises in the next cycle.
- **Throughput:** one pop per cycle on the input side; one capture per port per cycle on the output side. Downstream acceptance and a new capture can occur in the same cycle.
- **Registers:** all state is on rising `clk`. The only combinational paths are `req_in`→`io_in`, `full`→`src_ready`, and `snk_ready`-qualified updates.

## Test plan
- **Reset and idle:** reset, then idle → `src_ready`=4'hF, `snk_valid`=0, `io_in`=0, flags 0.
- **Input ordering, port 2:** push 5, −3, 7 into port 2, then `req_in`=4'b0100 for 3 cycles → `io_in` = 5, −3, 7 on successive cycles; the 4th request gives `io_in`=0 and `underrun[2]`=1.
- **Full and concurrent push/pop:** fill port 0 with 4 entries → `src_ready[0]`=0. Pop 1 → `src_ready[0]`=1 next cycle. Push and pop simultaneously → occupancy stays at 3.
- **Output capture and overrun:** `out_en`=4'b0010 with `io_out`=28'h0000123, `snk_ready`=0, then `out_en` again with 28'h0000456 → `snk_data` port 1 = 456, `overrun[1]`=1. Then `snk_ready[1]`=1 → `snk_valid[1]` clears.
- **Capture with same-cycle accept:** `out_en[3]` while `snk_valid[3]&snk_ready[3]` → new data loaded, `snk_valid[3]` stays 1, `overrun[3]`=0.
- **Multi-hot strobe and mid-stream reset:** `req_in`=4'b0110 → only port 1 pops. Asserting `rst` mid-stream → FIFOs empty immediately and all outputs return to their reset values.
